// File: rtl/cache_c1_frontend_if.sv
// Request/response handshake between the C1 bus frontend and the L1 cache core.
// The frontend is the master (issues requests), the core is the slave.
interface cache_c1_frontend_if #(
  parameter int ADDR_W = 15,
  parameter int OFF_W  = 4,
  parameter int DATA_W = 16
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [2:0]              req_cmd;
  logic [ADDR_W+OFF_W-1:0] req_addr;
  logic [2*DATA_W-1:0]     req_wdata;
  logic                    resp_valid;
  logic [2*DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/cache_c1_frontend.sv
// CPU-side C1/A1/D1 bus slave of the L1 cache: collects a command, forwards it to the core,
// returns the response on C1/D1. Optional WAIT timeout enabled by defining C1_TIMEOUT_EN.
module cache_c1_frontend #(
  parameter int ADDR_W  = 15,
  parameter int OFF_W   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  inout  wire  [2:0]          C1,
  input  logic [ADDR_W-1:0]   A1,
  inout  wire  [DATA_W-1:0]   D1,
  cache_c1_frontend_if.master core,
  output logic                busy,
  output logic                err
);

  localparam logic [2:0] CMD_RD8  = 3'd1;
  localparam logic [2:0] CMD_RD32 = 3'd3;
  localparam logic [2:0] CMD_WR8  = 3'd5;
  localparam logic [2:0] CMD_WR16 = 3'd6;
  localparam logic [2:0] CMD_WR32 = 3'd7;
  localparam logic [2:0] CMD_RESP = 3'd7;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cache_c1_frontend: TIMEOUT must fit the 8-bit WAIT counter (1..255)");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR2, TURN, REQ, WAIT, RESP0, RESP1, REL
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   tagset_q, tagset_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]          c1_in;
  logic [DATA_W-1:0]   d1_in;
  logic                cmd_hit;
  logic                cmd_is_rd;
  logic                c1_oe, d1_oe;
  logic [DATA_W-1:0]   d1_out;

  assign c1_in = C1;
  assign d1_in = D1;

  // Only a fully known code 1..7 starts a transaction; x/z/0 all read as NOP.
  always_comb begin
    cmd_hit = 1'b0;
    for (int k = 1; k < 8; k++)
      if (c1_in === 3'(k)) cmd_hit = 1'b1;
  end

  assign cmd_is_rd = ~cmd_q[2] & (|cmd_q[1:0]);

`ifdef C1_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tagset_d = tagset_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef C1_TIMEOUT_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_hit) begin
          cmd_d    = c1_in;
          tagset_d = A1;
          wdata_d  = '0;
          if (c1_in == CMD_WR8)
            wdata_d[7:0] = d1_in[7:0];
          else if (c1_in == CMD_WR16 || c1_in == CMD_WR32)
            wdata_d[DATA_W-1:0] = d1_in;
          state_d  = ADDR2;
        end
      end
      ADDR2: begin
        off_d = A1[OFF_W-1:0];
        if (cmd_q == CMD_WR32) wdata_d[2*DATA_W-1:DATA_W] = d1_in;
        state_d = TURN;
      end
      TURN:  state_d = REQ;
      REQ:   if (core.req_ready) state_d = WAIT;
      WAIT: begin
        if (core.resp_valid) begin
          rdata_d = core.resp_rdata;
          state_d = RESP0;
        end
`ifdef C1_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP0;
        end
`endif
      end
      RESP0: state_d = (cmd_q == CMD_RD32) ? RESP1 : REL;
      RESP1: state_d = REL;
      REL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      tagset_q <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      tagset_q <= tagset_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef C1_TIMEOUT_EN
  // Counter restarts on every entry into WAIT, so each request gets a full TIMEOUT window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WAIT)      cnt_d = cnt_q + 8'd1;
    if (state_q != WAIT && state_d == WAIT) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Request is dropped combinationally by reset so the core never sees a stale request.
  assign core.req_valid = (state_q == REQ) && rst_n;
  assign core.req_cmd   = cmd_q;
  assign core.req_addr  = {tagset_q, off_q};
  assign core.req_wdata = wdata_q;

  assign busy  = (state_q != IDLE);
  assign c1_oe = (state_q == RESP0) || (state_q == RESP1);
  assign d1_oe = c1_oe && cmd_is_rd;

  always_comb begin
    d1_out = rdata_q[DATA_W-1:0];
    if (state_q == RESP1)
      d1_out = rdata_q[2*DATA_W-1:DATA_W];
    else if (cmd_q == CMD_RD8)
      d1_out = {{(DATA_W-8){1'b0}}, rdata_q[7:0]};
  end

  assign C1 = c1_oe ? CMD_RESP : 3'bzzz;
  assign D1 = d1_oe ? d1_out   : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cache_c1_frontend.sv
// Directed bench for cache_c1_frontend: CPU bus driver, core handshake driver and
// request/response scoreboards. Timeout cases build only with C1_TIMEOUT_EN.
module tb_cache_c1_frontend;

  localparam int ADDR_W = 15, OFF_W = 4, DATA_W = 16;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        oe;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en;
  logic [2:0]  cpu_c1;
  logic [14:0] a1;
  logic [15:0] cpu_d1;
  logic        busy, err;
  wire  [2:0]  C1;
  wire  [15:0] D1;

  int          nvec = 0;
  int          nerr = 0;
  int unsigned cyc  = 0;

  req_t  req_q[$];
  beat_t beat_q[$];

  assign C1 = cpu_en ? cpu_c1 : 3'bzzz;
  assign D1 = cpu_en ? cpu_d1 : 16'hzzzz;

  cache_c1_frontend_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) cif ();

  cache_c1_frontend #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .C1    (C1),
    .A1    (a1),
    .D1    (D1),
    .core  (cif.master),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full transaction; rsp_dly < 0 means the core never answers.
  task automatic txn(input logic [2:0] cmd, input logic [14:0] a0, input logic [15:0] d0,
                     input logic [14:0] a1v, input logic [15:0] d1v,
                     input int rdy_dly, input int rsp_dly, input logic [31:0] rd,
                     input int exp_lat);
    req_t        er;
    beat_t       b;
    logic [31:0] rdv;
    logic        exp_err, seen, first;
    int          cnt;
    int unsigned c0;
    exp_err = (rsp_dly < 0);
    rdv     = exp_err ? 32'h0 : rd;
    er.cmd  = cmd;
    er.addr = {a0, a1v[3:0]};
    case (cmd)
      3'd5:    er.wdata = {24'h0, d0[7:0]};
      3'd6:    er.wdata = {16'h0, d0};
      3'd7:    er.wdata = {d1v, d0};
      default: er.wdata = 32'h0;
    endcase
    req_q.push_back(er);
    case (cmd)
      3'd1:    beat_q.push_back({1'b1, 8'h00, rdv[7:0]});
      3'd2:    beat_q.push_back({1'b1, rdv[15:0]});
      3'd3: begin
        beat_q.push_back({1'b1, rdv[15:0]});
        beat_q.push_back({1'b1, rdv[31:16]});
      end
      default: beat_q.push_back({1'b0, 16'h0000});
    endcase

    c0 = cyc;
    cpu_en = 1'b1; cpu_c1 = cmd; a1 = a0; cpu_d1 = d0;
    tick();
    cpu_c1 = 3'd5; a1 = a1v; cpu_d1 = d1v;
    tick();
    cpu_en = 1'b0;

    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (cif.req_valid) begin
        er = req_q[0];
        chk("req_cmd",   {29'h0, cif.req_cmd}, {29'h0, er.cmd});
        chk("req_addr",  {13'h0, cif.req_addr}, {13'h0, er.addr});
        chk("req_wdata", cif.req_wdata, er.wdata);
        if (cnt == rdy_dly) begin
          cif.req_ready = 1'b1;
          seen = 1'b1;
        end
        cnt++;
      end
    end
    chk("req_seen", {31'h0, seen}, 32'h1);
    if (seen) begin
      void'(req_q.pop_front());
      @(posedge clk); #1;
    end else req_q.delete();
    cif.req_ready = 1'b0;

    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      cif.resp_valid = 1'b0;
      if (i == 0) chk("req_drop", {31'h0, cif.req_valid}, 32'h0);
      if (dut.c1_oe) seen = 1'b1;
      else begin
        if (cnt == rsp_dly) begin
          cif.resp_valid = 1'b1;
          cif.resp_rdata = rd;
        end
        cnt++;
      end
    end
    cif.resp_valid = 1'b0;
    chk("resp_seen", {31'h0, seen}, 32'h1);
    if (seen && exp_lat > 0) chk("latency", cyc - c0, exp_lat);

    first = 1'b1;
    while (seen && beat_q.size() > 0) begin
      b = beat_q.pop_front();
      chk("resp_c1_oe", {31'h0, dut.c1_oe}, 32'h1);
      chk("resp_c1",    {29'h0, C1}, 32'h7);
      chk("resp_d1_oe", {31'h0, dut.d1_oe}, {31'h0, b.oe});
      if (b.oe) chk("resp_d1", {16'h0, D1}, {16'h0, b.data});
      if (first) chk("resp_err", {31'h0, err}, {31'h0, exp_err});
      first = 1'b0;
      @(negedge clk);
    end
    if (seen) begin
      chk("rel_c1_oe", {31'h0, dut.c1_oe}, 32'h0);
      chk("rel_d1_oe", {31'h0, dut.d1_oe}, 32'h0);
      chk("rel_busy",  {31'h0, busy}, 32'h1);
      chk("rel_err",   {31'h0, err}, 32'h0);
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'h0);
    end else begin
      beat_q.delete();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_en = 1'b0; cpu_c1 = 3'd0; a1 = '0; cpu_d1 = '0;
    cif.req_ready = 1'b0; cif.resp_valid = 1'b0; cif.resp_rdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy",      {31'h0, busy}, 32'h0);
    chk("rst_req_valid", {31'h0, cif.req_valid}, 32'h0);
    chk("rst_err",       {31'h0, err}, 32'h0);
    chk("rst_c1_oe",     {31'h0, dut.c1_oe}, 32'h0);
    chk("rst_d1_oe",     {31'h0, dut.d1_oe}, 32'h0);
    rst_n = 1'b1;

    // bus floating, then explicit NOP: must stay idle
    for (int i = 0; i < 10; i++) begin
      cpu_en = (i >= 5); cpu_c1 = 3'd0;
      @(negedge clk);
      chk("nop_busy",      {31'h0, busy}, 32'h0);
      chk("nop_req_valid", {31'h0, cif.req_valid}, 32'h0);
    end
    cpu_en = 1'b0;

    txn(3'd3, 15'h0003, 16'h0000, 15'h0002, 16'h0000, 0, 0, 32'hDEADBEEF, 5);
    txn(3'd7, 15'h0010, 16'h1234, 15'h0008, 16'h5678, 0, 1, 32'h0, 0);
    txn(3'd2, 15'h7ABC, 16'h0000, 15'h000F, 16'h0000, 4, 2, 32'h0000CAFE, 0);
    txn(3'd5, 15'h1111, 16'hA5C3, 15'h0001, 16'hFFFF, 1, 0, 32'h0, 0);
    txn(3'd6, 15'h2222, 16'hBEEF, 15'h0007, 16'h9999, 0, 3, 32'h0, 0);
    txn(3'd4, 15'h4000, 16'h0000, 15'h000A, 16'h0000, 2, 1, 32'h0, 0);
    txn(3'd1, 15'h0055, 16'h0000, 15'h0004, 16'h0000, 0, 0, 32'h123456C7, 5);

    // reset in WAIT aborts the transaction
    cpu_en = 1'b1; cpu_c1 = 3'd2; a1 = 15'h0123; cpu_d1 = 16'h0;
    tick();
    a1 = 15'h0006;
    tick();
    cpu_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_req_valid", {31'h0, cif.req_valid}, 32'h1);
    cif.req_ready = 1'b1;
    @(posedge clk); #1;
    cif.req_ready = 1'b0;
    @(negedge clk);
    chk("rw_busy_wait", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_busy",      {31'h0, busy}, 32'h0);
    chk("rw_c1_oe",     {31'h0, dut.c1_oe}, 32'h0);
    chk("rw_d1_oe",     {31'h0, dut.d1_oe}, 32'h0);
    chk("rw_req_valid0",{31'h0, cif.req_valid}, 32'h0);
    rst_n = 1'b1;
    cif.resp_valid = 1'b1; cif.resp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cif.resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw_no_resp", {30'h0, dut.c1_oe, busy}, 32'h0);
    end
    txn(3'd1, 15'h0321, 16'h0000, 15'h0009, 16'h0000, 0, 0, 32'h000000AB, 5);

`ifdef C1_TIMEOUT_EN
    txn(3'd2, 15'h0044, 16'h0000, 15'h0003, 16'h0000, 0, -1, 32'h0000BBBB, 0);
    txn(3'd2, 15'h0045, 16'h0000, 15'h0003, 16'h0000, 0, 3, 32'h00007777, 0);
    txn(3'd3, 15'h0046, 16'h0000, 15'h0001, 16'h0000, 0, -1, 32'h12345678, 0);
`else
    txn(3'd3, 15'h0046, 16'h0000, 15'h0001, 16'h0000, 0, 300, 32'h87654321, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
